// File: rtl/apb_uart_pkg.sv
// Shared types and constants for the APB UART receive slice.
// Holds the receiver FSM states, frame-mode codes, data-bit counts and size defaults.
package apb_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic MODE_8B  = 1'b0;
    localparam logic MODE_10B = 1'b1;

    localparam logic [3:0] NBITS_8  = 4'd8;
    localparam logic [3:0] NBITS_10 = 4'd10;

    localparam int BAUD_W_DEF = 20;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/apb_uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a falling-edge detector.
// Ports: clk, rstn (sync, active-high), line (async serial in),
//        line_sync (synchronised line), fall (one-cycle falling-edge pulse).
module apb_uart_rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic line,
    output logic line_sync,
    output logic fall
);

    logic meta;
    logic prev;

    // All flops reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rstn) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
            prev      <= 1'b1;
        end else begin
            meta      <= line;
            line_sync <= meta;
            prev      <= line_sync;
        end
    end

    assign fall = prev & ~line_sync;

endmodule

// File: rtl/apb_uart_rx.sv
// UART receiver slice: latches bit divisor and frame mode, then deserialises frames
// on rx_in into a zero-extended data register.
// Ports: clk, rstn (sync, active-high), sel, rx_en, mode (0=8b, 1=10b),
//        baud (clocks per bit), rx_in (idle high), rx_data (last good frame).
// Build option: APB_UART_RX_PARITY_EN adds one even-parity bit before the stop bit.
module apb_uart_rx
    import apb_uart_pkg::*;
#(
    parameter int BAUD_W = BAUD_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sel,
    input  logic              rx_en,
    input  logic              mode,
    input  logic [BAUD_W-1:0] baud,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_data
);

    rx_state_t         state;
    logic [BAUD_W-1:0] cfg_baud;
    logic              cfg_mode;
    logic [BAUD_W-1:0] timer;
    logic [3:0]        bit_cnt;
    logic [9:0]        shreg;
    logic              ferr;

    logic              rxs;
    logic              fall;

    logic              cfg_wr;
    logic              rx_act;
    logic              baud_ok;
    logic              half_hit;
    logic              bit_hit;
    logic              good;
    logic [3:0]        n_bits;
    logic [9:0]        mask;

    apb_uart_rx_sync u_sync (
        .clk       (clk),
        .rstn      (rstn),
        .line      (rx_in),
        .line_sync (rxs),
        .fall      (fall)
    );

    assign cfg_wr   = sel & ~rx_en;
    assign rx_act   = sel & rx_en;
    assign baud_ok  = cfg_baud >= BAUD_W'(2);
    assign half_hit = timer == (cfg_baud >> 1) - BAUD_W'(1);
    assign bit_hit  = timer == cfg_baud - BAUD_W'(1);
    assign n_bits   = (cfg_mode == MODE_10B) ? NBITS_10 : NBITS_8;
    assign mask     = (cfg_mode == MODE_10B) ? 10'h3FF : 10'h0FF;

`ifdef APB_UART_RX_PARITY_EN
    logic par_err;
    assign good = ~par_err;
`else
    assign good = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rstn) begin
            rx_data  <= '0;
            cfg_baud <= '0;
            cfg_mode <= MODE_8B;
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ferr     <= 1'b0;
`ifdef APB_UART_RX_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
            // Config can only change while the receiver is off, so never mid-frame.
            if (cfg_wr) begin
                cfg_baud <= baud;
                cfg_mode <= mode;
            end

            if (!rx_act) begin
                state <= IDLE;
                timer <= '0;
                ferr  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (fall && baud_ok) begin
                            state <= START;
                            timer <= '0;
                        end
                    end
                    START: begin
                        // Half-bit check: a line already back high was a glitch.
                        if (half_hit) begin
                            timer <= '0;
                            if (!rxs) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                                shreg   <= '0;
`ifdef APB_UART_RX_PARITY_EN
                                par_err <= 1'b0;
`endif
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            timer <= timer + BAUD_W'(1);
                        end
                    end
                    DATA: begin
                        if (bit_hit) begin
                            timer          <= '0;
                            shreg[bit_cnt] <= rxs;
                            if (bit_cnt == n_bits - 4'd1) begin
`ifdef APB_UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            timer <= timer + BAUD_W'(1);
                        end
                    end
`ifdef APB_UART_RX_PARITY_EN
                    PARITY: begin
                        if (bit_hit) begin
                            timer   <= '0;
                            par_err <= (^shreg) ^ rxs;
                            state   <= STOP;
                        end else begin
                            timer <= timer + BAUD_W'(1);
                        end
                    end
`endif
                    STOP: begin
                        // After a framing error, hold off until the line idles high.
                        if (ferr) begin
                            if (rxs) begin
                                ferr  <= 1'b0;
                                state <= IDLE;
                            end
                        end else if (bit_hit) begin
                            timer <= '0;
                            if (rxs) begin
                                if (good) begin
                                    rx_data <= DATA_W'(shreg & mask);
                                end
                                state <= IDLE;
                            end else begin
                                ferr <= 1'b1;
                            end
                        end else begin
                            timer <= timer + BAUD_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_uart_rx.sv
// Self-checking bench for apb_uart_rx: scoreboard of expected frames and latencies,
// plus direct checks that bad, glitched, aborted and reset frames leave rx_data alone.
module tb_apb_uart_rx;

    localparam int BAUD_W = 20;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              sel;
    logic              rx_en;
    logic              mode;
    logic [BAUD_W-1:0] baud;
    logic              rx_in;
    logic [DATA_W-1:0] rx_data;

    apb_uart_rx #(
        .BAUD_W (BAUD_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sel     (sel),
        .rx_en   (rx_en),
        .mode    (mode),
        .baud    (baud),
        .rx_in   (rx_in),
        .rx_data (rx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int unsigned t0;
        int unsigned lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [31:0] last_seen = '0;
    logic [31:0] good_val = '0;
    int          cur_baud = 16;
    int          cur_n = 8;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Every rx_data change outside reset must match the next scoreboard entry.
    always @(negedge clk) begin : mon
        exp_t        e;
        int unsigned lat;
        if (rstn) begin
            last_seen = rx_data;
        end else if (rx_data !== last_seen) begin
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                lat = cyc - e.t0;
                chk("rx_data", rx_data, e.data);
                chk("rx_lat_ok",
                    32'(lat >= e.lat && lat <= e.lat + 2), 32'd1);
            end else begin
                chk("rx_unexpected", rx_data, last_seen);
            end
            last_seen = rx_data;
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic cfg(input int b, input logic m);
        idle(1);
        sel   = 1'b1;
        rx_en = 1'b0;
        baud  = BAUD_W'(b);
        mode  = m;
        idle(2);
        rx_en    = 1'b1;
        cur_baud = b;
        cur_n    = m ? 10 : 8;
        idle(4);
    endtask

    // act: 0 none, 1 drop rx_en, 2 pulse rstn -- applied at the start of frame bit act_bit.
    task automatic send(input logic [9:0] data, input logic stop,
                        input int act_bit, input int act, input logic ok);
        logic bits[0:12];
        logic par;
        int   nb;
        exp_t e;
        par     = 1'b0;
        bits[0] = 1'b0;
        for (int i = 0; i < cur_n; i++) begin
            bits[1+i] = data[i];
            par       = par ^ data[i];
        end
        nb = cur_n + 1;
`ifdef APB_UART_RX_PARITY_EN
        bits[nb] = par;
        nb++;
`endif
        bits[nb] = stop;
        nb++;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < cur_baud; c++) begin
                @(negedge clk);
                #1;
                if (i == 0 && c == 0 && ok) begin
                    e.data = 32'(data) & (cur_n == 10 ? 32'h3FF : 32'hFF);
                    e.t0   = cyc;
                    e.lat  = 2 + cur_baud / 2 + (cur_n + 1) * cur_baud;
`ifdef APB_UART_RX_PARITY_EN
                    e.lat  = e.lat + cur_baud;
`endif
                    exp_q.push_back(e);
                    good_val = e.data;
                end
                rx_in = bits[i];
                if (i == act_bit && c == 0) begin
                    if (act == 1) rx_en = 1'b0;
                    if (act == 2) rstn = 1'b1;
                end
                if (i == act_bit && c == 1 && act == 2) rstn = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        rx_in = 1'b1;
        idle(cur_baud + 4);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            idle(1);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        rstn  = 1'b1;
        sel   = 1'b0;
        rx_en = 1'b0;
        mode  = 1'b0;
        baud  = '0;
        rx_in = 1'b1;
        idle(2);
        rstn = 1'b0;
        idle(1);
        chk("reset_data", rx_data, 32'h0);
        idle(100);
        chk("idle_data", rx_data, 32'h0);

        cfg(16, 1'b0);
        send(10'h035, 1'b1, -1, 0, 1'b1);
        drain(400);

        send(10'h0A5, 1'b0, -1, 0, 1'b0);
        idle(20);
        chk("bad_stop", rx_data, 32'h35);
        send(10'h05A, 1'b1, -1, 0, 1'b1);
        drain(400);

        cfg(20, 1'b1);
        send(10'b1100001010, 1'b1, -1, 0, 1'b1);
        drain(400);

        cfg(16, 1'b0);
        rx_in = 1'b0;
        idle(4);
        rx_in = 1'b1;
        idle(40);
        chk("glitch", rx_data, 32'h30A);
        send(10'h012, 1'b1, -1, 0, 1'b1);
        drain(400);

        send(10'h0FF, 1'b1, 5, 1, 1'b0);
        idle(4);
        rx_en = 1'b1;
        idle(4);
        chk("abort", rx_data, 32'h12);

        baud = BAUD_W'(8);
        idle(4);
        send(10'h03C, 1'b1, -1, 0, 1'b1);
        drain(400);
        chk("cfg_ignored", rx_data, 32'h3C);
        baud = BAUD_W'(16);

        send(10'h077, 1'b1, 3, 2, 1'b0);
        chk("mid_reset", rx_data, 32'h0);

        cfg(16, 1'b0);
        send(10'h081, 1'b1, -1, 0, 1'b1);
        drain(400);
        chk("final", rx_data, good_val);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
